exec_muldiv: RTL and testbench
==============================

EXEC_MULDIV -- requirements
Module: exec_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning operand and result width.
REQ-002 SHALL have port i_clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port i_arstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_start  input  1  request from the execute stage; an M-extension instruction is present.
REQ-005 SHALL have port i_func3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports i_rs1_data and i_rs2_data  input  DATA_WIDTH  forwarded operands from the decode/execute pipeline register.
REQ-007 SHALL have port i_flush  input  1  abort of any in-flight operation (branch mispredict or trap).
REQ-008 SHALL have port o_stall  output  1  hold signal to the fetch, decode and decode/execute registers.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse; o_result is valid in this cycle.
REQ-010 SHALL have port o_result  output  DATA_WIDTH  operation result.
REQ-011 SHALL have port i_word  input  1  select RV64 W-variant; the port exists only with MULDIV_WORD_EN.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL, in IDLE with i_start=1 and i_flush=0, latch operands and op at the clock edge and enter CALC.
- Exception: divide special cases go directly to DONE.
REQ-014 SHALL perform an iterative shift-add multiply and a restoring divide, one bit per cycle, for DATA_WIDTH CALC cycles, then enter DONE.
REQ-015 SHALL convert signed operands to magnitudes on entry and fix result signs in DONE.
- MULH/MULHSU/MULHU: upper half of the 2*DATA_WIDTH product.
- MUL: lower half of the product.
REQ-016 SHALL assert o_done for exactly the one DONE cycle, then return to IDLE.
- Normal op: DONE is DATA_WIDTH+1 cycles after the start edge.
- Special case: DONE is 1 cycle after the start edge.
REQ-017 SHALL, on divide by zero, return:
- DIV and DIVU: all ones.
- REM and REMU: the dividend.
REQ-018 SHALL, on signed overflow (most-negative / -1), return:
- DIV: most-negative.
- REM: 0.
REQ-019 SHALL drive o_stall = (IDLE & i_start & ~i_flush) | CALC, combinationally; o_stall SHALL be 0 in DONE.
REQ-020 SHALL ignore i_start in CALC and DONE.
REQ-021 SHALL, on i_flush=1 in any state, enter IDLE at the next edge.
- No o_done is issued for the aborted operation.
- i_flush overrides a simultaneous i_start.
REQ-022 SHALL hold o_result at its last DONE value until the next DONE.

Reset
REQ-023 SHALL, while i_arstn=0 and independent of the clock, force: state IDLE, o_done 0, o_result 0, internal accumulators and counter 0.
REQ-024 SHALL, on reset mid-operation, discard the operation with no o_done after release.

Configuration
REQ-025 SHALL, when MULDIV_WORD_EN is defined, provide port i_word with the following behaviour when i_word=1:
- Operands are the low 32 bits, sign- or zero-extended per op.
- The operation runs 32 CALC cycles.
- The 32-bit result is sign-extended to DATA_WIDTH.
- func3 001/010/011 behave as MULW.
REQ-026 SHALL, when MULDIV_WORD_EN is undefined, omit i_word and always operate on full DATA_WIDTH.

Verification
REQ-027 SHALL cover MUL: rs1=7, rs2=-3 -> o_done at start+65, o_result=-21 (0xFFFF_FFFF_FFFF_FFEB).
REQ-028 SHALL cover MULHU: rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> o_result=0xFFFF_FFFF_FFFF_FFFE.
REQ-029 SHALL cover DIV: rs1=-20, rs2=6 -> o_result=-3; REM with the same operands -> o_result=-2; o_stall high for 65 cycles.
REQ-030 SHALL cover DIVU with rs2=0 -> o_done at start+1, o_result=all ones; REM 0x8000_0000_0000_0000 / -1 -> o_result=0.
REQ-031 SHALL cover i_flush at cycle 10 of CALC -> IDLE next edge, no o_done, o_result unchanged; new start is accepted next cycle.
REQ-032 SHALL cover, with MULDIV_WORD_EN, DIVW: rs1=0x1_8000_0000, rs2=-1 -> o_done at start+1, o_result=0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative RISC-V M-extension unit (shift-add multiply, restoring divide, one bit per cycle).
// Define MULDIV_WORD_EN to add the i_word port for RV64 W-variant operations.
module exec_muldiv #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_start,
  input  logic [2:0]            i_func3,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
`ifdef MULDIV_WORD_EN
  input  logic                  i_word,
`endif
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;

  logic [W-1:0]  acc, qreg, mcand;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic          word_q, neg_q;

  logic word_in;
`ifdef MULDIV_WORD_EN
  assign word_in = i_word;
`else
  assign word_in = 1'b0;
`endif

  function automatic logic [W-1:0] sext32(input logic [W-1:0] v);
    return {{(W-32){v[31]}}, v[31:0]};
  endfunction

  // Operand preparation and divide special cases, evaluated on the start cycle
  logic         is_div, sgn_a, sgn_b, a_neg, b_neg, b_zero, ovf, special;
  logic [W-1:0] a_ext, b_ext, a_mag, b_mag, min_mag, spec_res;

  always_comb begin
    is_div = i_func3[2];
    sgn_a  = is_div ? ~i_func3[0] : (~word_in & ((i_func3[1:0] == 2'b01) | (i_func3[1:0] == 2'b10)));
    sgn_b  = is_div ? ~i_func3[0] : (~word_in & (i_func3[1:0] == 2'b01));
    a_ext  = i_rs1_data;
    b_ext  = i_rs2_data;
    if (word_in) begin
      a_ext = sgn_a ? sext32(i_rs1_data) : {{(W-32){1'b0}}, i_rs1_data[31:0]};
      b_ext = sgn_b ? sext32(i_rs2_data) : {{(W-32){1'b0}}, i_rs2_data[31:0]};
    end
    a_neg   = sgn_a & a_ext[W-1];
    b_neg   = sgn_b & b_ext[W-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    min_mag = word_in ? (W'(1) << 31) : (W'(1) << (W-1));
    b_zero  = (b_ext == '0);
    ovf     = sgn_a & a_neg & (a_mag == min_mag) & (b_ext == '1);
    special = is_div & (b_zero | ovf);
    spec_res = '0;
    if (b_zero)   spec_res = i_func3[1] ? a_ext : '1;
    else if (ovf) spec_res = i_func3[1] ? '0 : a_ext;
    if (word_in)  spec_res = sext32(spec_res);
  end

  // One iteration step plus the sign-corrected result of the final step
  logic [W:0]     sum, shifted;
  logic           ge;
  logic [W-1:0]   acc_n, qreg_n, fin_res;
  logic [2*W-1:0] prod, prod_s;
  logic [CW-1:0]  last_cnt;

  always_comb begin
    acc_n   = acc;
    qreg_n  = qreg;
    sum     = '0;
    shifted = '0;
    ge      = 1'b0;
    if (op_q[2]) begin
      shifted = {acc, qreg[W-1]};
      ge      = shifted >= {1'b0, mcand};
      acc_n   = ge ? (shifted[W-1:0] - mcand) : shifted[W-1:0];
      qreg_n  = {qreg[W-2:0], ge};
    end else begin
      sum = {1'b0, acc} + (qreg[0] ? {1'b0, mcand} : '0);
      {acc_n, qreg_n} = {sum, qreg[W-1:1]};
    end
    prod   = {acc_n, qreg_n};
    prod_s = neg_q ? -prod : prod;
    if (op_q[2]) begin
      fin_res = op_q[1] ? acc_n : qreg_n;
      if (neg_q) fin_res = -fin_res;
    end else if (word_q) begin
      // 32 shifts leave the low product word in the top half of qreg
      fin_res = {{(W-32){1'b0}}, qreg_n[W-1 -: 32]};
    end else if (op_q[1:0] == 2'b00) begin
      fin_res = prod_s[W-1:0];
    end else begin
      fin_res = prod_s[2*W-1:W];
    end
    if (word_q) fin_res = sext32(fin_res);
    last_cnt = word_q ? CW'(31) : CW'(W-1);
  end

  assign o_stall = ((state == IDLE) & i_start & ~i_flush) | (state == CALC);

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state    <= IDLE;
      o_done   <= 1'b0;
      o_result <= '0;
      acc      <= '0;
      qreg     <= '0;
      mcand    <= '0;
      cnt      <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else if (i_flush) begin
      state  <= IDLE;
      o_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            op_q   <= i_func3;
            word_q <= word_in;
            cnt    <= '0;
            acc    <= '0;
            if (is_div) begin
              // word divides start with the dividend in the top 32 bits so 32 shifts suffice
              qreg  <= word_in ? (a_mag << (W-32)) : a_mag;
              mcand <= b_mag;
              neg_q <= i_func3[1] ? a_neg : (a_neg ^ b_neg);
            end else begin
              qreg  <= b_mag;
              mcand <= a_mag;
              neg_q <= a_neg ^ b_neg;
            end
            if (special) begin
              state    <= DONE;
              o_done   <= 1'b1;
              o_result <= spec_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc  <= acc_n;
          qreg <= qreg_n;
          cnt  <= cnt + 1'b1;
          if (cnt == last_cnt) begin
            state    <= DONE;
            o_done   <= 1'b1;
            o_result <= fin_res;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_muldiv.sv
// Self-checking bench for exec_muldiv: directed vector table, random ops against an arithmetic model,
// and hand sequences for flush, reset and (with MULDIV_WORD_EN) word operations.
module tb_exec_muldiv;
  localparam int unsigned W = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         arstn, start, flush, word;
  logic [2:0]   func3;
  logic [W-1:0] rs1, rs2, result;
  logic         stall, done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  exec_muldiv #(.DATA_WIDTH(W)) dut (
    .i_clk      (clk),
    .i_arstn    (arstn),
    .i_start    (start),
    .i_func3    (func3),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
`ifdef MULDIV_WORD_EN
    .i_word     (word),
`endif
    .i_flush    (flush),
    .o_stall    (stall),
    .o_done     (done),
    .o_result   (result)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 128-bit products and SV signed division, with RISC-V corner-case rules
  function automatic logic [63:0] ref_res(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       pa, pb, p;
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    pa = (f == 3'd1 || f == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
    pb = (f == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = pa * pb;
    case (f)
      3'd0: return p[63:0];
      3'd1, 3'd2, 3'd3: return p[127:64];
      3'd4: begin
        if (b == 64'd0) return '1;
        if (a == MIN64 && b == '1) return MIN64;
        return sa / sb;
      end
      3'd5: return (b == 64'd0) ? '1 : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == MIN64 && b == '1) return 64'd0;
        return sa % sb;
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    if (f[2] && (b == 64'd0 || (!f[0] && a == MIN64 && b == '1))) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle (or after the cycle budget)
  task automatic run_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output int stalls);
    start = 1'b1;
    func3 = f;
    rs1   = a;
    rs2   = b;
    #1;
    stalls = stall ? 1 : 0;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (stall) stalls++;
    end
    res = result;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[16];
  logic [63:0] res, exp_r, a, b;
  int          lat, st, cnt_done, cnt_stall;
  logic [2:0]  f;

  initial begin
    vecs[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[4]  = '{3'd5, 64'd123, 64'd0, '1, 1};
    vecs[5]  = '{3'd6, MIN64, '1, 64'd0, 1};
    vecs[6]  = '{3'd4, MIN64, '1, MIN64, 1};
    vecs[7]  = '{3'd7, 64'h55, 64'd0, 64'h55, 1};
    vecs[8]  = '{3'd1, '1, '1, 64'd0, 65};
    vecs[9]  = '{3'd2, '1, '1, '1, 65};
    vecs[10] = '{3'd5, 64'd100, 64'd7, 64'd14, 65};
    vecs[11] = '{3'd7, 64'd100, 64'd7, 64'd2, 65};
    vecs[12] = '{3'd4, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[13] = '{3'd6, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'd2, 65};
    vecs[14] = '{3'd1, MIN64, MIN64, 64'h4000_0000_0000_0000, 65};
    vecs[15] = '{3'd4, 64'd0, 64'd0, '1, 1};

    arstn = 1'b0; start = 1'b0; flush = 1'b0; word = 1'b0;
    func3 = 3'd0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    arstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, st);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_stall_cycles", i), 64'(st), 64'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_hold", i), result, vecs[i].exp);
    end

    for (int i = 0; i < 120; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rnd_op();
      b = rnd_op();
      exp_r = ref_res(f, a, b);
      run_op(f, a, b, res, lat, st);
      check($sformatf("rand%0d_f%0d_result", i, f), res, exp_r);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_lat(f, a, b)));
      @(negedge clk);
    end

    // flush during CALC cycle 10
    exp_r = result;
    start = 1'b1; func3 = 3'd4; rs1 = 64'd100; rs2 = 64'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_stall_in_calc", 64'(stall), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_no_done", 64'(done), 64'd0);
    check("flush_stall_low", 64'(stall), 64'd0);
    check("flush_result_held", result, exp_r);
    run_op(3'd5, 64'd1000, 64'd7, res, lat, st);
    check("after_flush_result", res, 64'd142);
    check("after_flush_latency", 64'(lat), 64'd65);
    @(negedge clk);

    // flush overrides a simultaneous start
    start = 1'b1; flush = 1'b1; func3 = 3'd0; rs1 = 64'd5; rs2 = 64'd5;
    #1;
    check("start_flush_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    cnt_done = 0; cnt_stall = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (stall) cnt_stall++;
    end
    check("start_flush_no_done", 64'(cnt_done), 64'd0);
    check("start_flush_no_calc", 64'(cnt_stall), 64'd0);

    // asynchronous reset mid-operation
    start = 1'b1; func3 = 3'd1; rs1 = 64'd9; rs2 = 64'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    check("midreset_result", result, 64'd0);
    check("midreset_stall", 64'(stall), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    cnt_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("midreset_no_done", 64'(cnt_done), 64'd0);
    run_op(3'd0, 64'd6, 64'd7, res, lat, st);
    check("after_reset_result", res, 64'd42);
    @(negedge clk);

`ifdef MULDIV_WORD_EN
    word = 1'b1;
    run_op(3'd4, 64'h1_8000_0000, '1, res, lat, st);
    check("divw_ovf_result", res, 64'hFFFF_FFFF_8000_0000);
    check("divw_ovf_latency", 64'(lat), 64'd1);
    @(negedge clk);
    run_op(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, res, lat, st);
    check("mulw_result", res, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mulw_latency", 64'(lat), 64'd33);
    @(negedge clk);
    word = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
